// File: rtl/cpu_pkg.sv
// Shared definitions for the execute controller and its register file.
// It holds the opcode and ALU opcode constants, the FSM state enum,
// the instruction field positions and the sign-extension helpers.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int REG_AW = 3;

   // Instruction opcodes (inst[15:12])
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_CMP  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_BR   = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   // ALU opcodes; these share values with OP_ADD..OP_CMP
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_CMP = 4'h4;

   // Instruction field positions
   localparam int OP_HI   = 15;
   localparam int OP_LO   = 12;
   localparam int RD_HI   = 11;
   localparam int RD_LO   = 9;
   localparam int RS1_HI  = 8;
   localparam int RS1_LO  = 6;
   localparam int RS2_HI  = 5;
   localparam int RS2_LO  = 3;
   localparam int IMM6_HI = 5;
   localparam int OFF9_HI = 8;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   function automatic logic [DATA_W-1:0] sext6(input logic [5:0] value);
      return {{(DATA_W-6){value[5]}}, value};
   endfunction

   function automatic logic [DATA_W-1:0] sext9(input logic [8:0] value);
      return {{(DATA_W-9){value[8]}}, value};
   endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8 x 16 register file.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset (clears all registers)
//   we, waddr, wdata  synchronous write port
//   raddr_a, rdata_a  combinational read port A
//   raddr_b, rdata_b  combinational read port B
//   dbg_addr, dbg_data combinational debug read port
module regfile_8x16
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [NREGS];

   // Register 0 is an ordinary register; every entry is cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a  = regs[raddr_a];
   assign rdata_b  = regs[raddr_b];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller driving a 16-bit ALU.
// Fetches instructions over a valid/ready handshake, reads operands from the
// internal register file, drives registered ALU inputs, captures the result
// and flags, writes back, updates the condition code and resolves branches.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pc                           address of the requested instruction
//   inst_valid/inst_ready/inst_data  fetch handshake
//   alu_a, alu_b, alu_op         registered ALU inputs
//   alu_result, alu_n/z/p        combinational ALU outputs
//   cc                           condition code {N,Z,P}
//   retire, halted, illegal      status
//   dbg_addr, dbg_data           register file debug read
module alu_exec_ctrl
   import cpu_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] pc,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [DATA_W-1:0] inst_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_p,
   output logic [2:0]        cc,
   output logic              retire,
   output logic              halted,
   output logic              illegal,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state, state_next;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] result_q;
   logic [2:0]        flags_q;
   logic [DATA_W-1:0] rdata_a, rdata_b;

   logic [3:0]        op;
   logic [REG_AW-1:0] rd, rs1, rs2;
   logic              is_alu, is_br, is_halt, br_taken, rf_we;

   assign op  = ir[OP_HI:OP_LO];
   assign rd  = ir[RD_HI:RD_LO];
   assign rs1 = ir[RS1_HI:RS1_LO];
   assign rs2 = ir[RS2_HI:RS2_LO];

   // Opcodes 0..5 are the register/immediate ALU group.
   assign is_alu   = (op <= OP_ADDI);
   assign is_br    = (op == OP_BR);
   assign is_halt  = (op == OP_HALT);
   // For BR the rd field carries the nzp mask.
   assign br_taken = |(rd & cc);
   assign rf_we    = (state == S_WB) && (op != OP_CMP);

   regfile_8x16 u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rd),
      .wdata    (result_q),
      .raddr_a  (rs1),
      .rdata_a  (rdata_a),
      .raddr_b  (rs2),
      .rdata_b  (rdata_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // State register; reset discards whatever instruction is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake/status outputs. BR and HALT retire straight
   // out of DECODE; an illegal opcode halts without retiring.
   always_comb begin
      state_next = state;
      inst_ready = 1'b0;
      retire     = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_alu) begin
               state_next = S_EXEC;
            end else if (is_br) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end else if (is_halt) begin
               retire     = 1'b1;
               state_next = S_HALT;
            end else begin
               state_next = S_HALT;
            end
         end
         S_EXEC: begin
            state_next = S_WB;
         end
         S_WB: begin
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   // Datapath registers. Operands are sampled in DECODE so an instruction
   // whose rd matches a source reads the old value; the write happens in WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         cc       <= 3'b010;
         ir       <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= ALU_ADD;
         result_q <= '0;
         flags_q  <= 3'b010;
         illegal  <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (inst_valid) begin
                  ir <= inst_data;
               end
            end
            S_DECODE: begin
               if (is_alu) begin
                  alu_a <= rdata_a;
                  if (op == OP_ADDI) begin
                     alu_b  <= sext6(ir[IMM6_HI:0]);
                     alu_op <= ALU_ADD;
                  end else begin
                     alu_b  <= rdata_b;
                     alu_op <= op;
                  end
               end else if (is_br) begin
                  pc <= pc + 16'd1 + (br_taken ? sext9(ir[OFF9_HI:0]) : 16'd0);
               end else if (!is_halt) begin
                  illegal <= 1'b1;
               end
            end
            S_EXEC: begin
               result_q <= alu_result;
               flags_q  <= {alu_n, alu_z, alu_p};
            end
            S_WB: begin
               cc <= flags_q;
               pc <= pc + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute controller that acts as the initiator for the 16-bit ALU. It performs the following per instruction:
- accepts instruction words over a valid/ready fetch handshake;
- decodes each word and reads operands from an internal 8x16 register file;
- drives the ALU operand and opcode inputs, then captures the ALU result and N/Z/P flags;
- writes back the result, updates the condition-code register and resolves conditional branches.

It sits between the instruction memory and the ALU in the CPU core.

Parameters:
- DATA_W, 16, datapath, register and PC width
- NREGS, 8, register file depth; index width is 3 bits
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc  out  16  address of the instruction being requested
- inst_valid  in  1  inst_data holds a valid instruction
- inst_ready  out  1  controller can accept an instruction
- inst_data  in  16  instruction word
- alu_a  out  16  ALU operand A (registered)
- alu_b  out  16  ALU operand B (registered)
- alu_op  out  4  ALU opcode (registered)
- alu_result  in  16  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_n, alu_z, alu_p  in  1 each  ALU flags
- cc  out  3  condition code {N,Z,P}
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  controller stopped
- illegal  out  1  stopped on an undefined opcode
- dbg_addr  in  3  register file debug read index
- dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
Encoding, with op = inst[15:12]:
- 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR: rd = [11:9], rs1 = [8:6], rs2 = [5:3].
- 0x4 CMP: rs1 and rs2 as above. ALU computes rs1-rs2. Only cc is updated; no register write.
- 0x5 ADDI: rd = [11:9], rs1 = [8:6], imm6 = [5:0] sign-extended. alu_op is 0000.
- 0x8 BR: mask = [11:9] (nzp), off9 = [8:0] sign-extended.
- 0xF HALT.
- Any other opcode is illegal.
- alu_op equals the opcode for 0x0–0x4.

FSM states: FETCH, DECODE, EXEC, WB, HALT.

FETCH:
- inst_ready = 1.
- On inst_valid & inst_ready, latch IR and go to DECODE.
- If inst_valid is low, stay in FETCH. pc is held stable.

DECODE:
- ALU ops: register alu_a = reg[rs1] and alu_b = reg[rs2] or sext(imm6); set alu_op; go to EXEC.
- BR: taken = |(mask & cc). pc <= pc + 1 + (taken ? sext(off9) : 0), modulo 2^16. Pulse retire, go to FETCH. Registers and cc are unchanged.
- HALT: go to HALT with halted = 1 and retire pulsed.
- Illegal opcode: go to HALT with halted = 1 and illegal = 1. retire is not pulsed.

EXEC:
- Capture alu_result and {alu_n, alu_z, alu_p} into internal registers.
- Go to WB.

WB:
- If the op is not CMP, write reg[rd].
- cc <= captured flags.
- pc <= pc + 1, wrapping 16'hFFFF to 0.
- Pulse retire, go to FETCH.

HALT:
- Absorbing. inst_ready = 0. Only rst exits.

Timing and register-file rules:
- ALU instruction: 4 cycles from handshake to the next inst_ready (FETCH, DECODE, EXEC, WB).
- BR and HALT: 2 cycles.
- Register 0 is general purpose; it is not hardwired to zero.
- rd == rs1 or rd == rs2 is legal. Operands are read in DECODE, before the WB write.

Reset (synchronous, highest priority, valid in any state, including mid-instruction):
- state = FETCH, pc = RESET_PC.
- cc = 3'b010.
- All registers = 0.
- alu_a = alu_b = 0, alu_op = 0.
- retire = halted = illegal = 0, inst_ready = 1 in the cycle after reset.
- An in-flight instruction is discarded with no write-back.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_ADD..OP_CMP, OP_ADDI, OP_BR, OP_HALT);
  - ALU op constants matching the ALU;
  - FSM state enum;
  - field position constants and the sign-extend helper.
- One sub-module: regfile_8x16, with 2 combinational read ports, 1 debug read port and 1 synchronous write port with write enable.
- FSM and datapath stay in alu_exec_ctrl.

Test Plan (bench instantiates alu_exec_ctrl and the real alu):
1. Reset, then ADDI r1, r0, 10 and ADDI r2, r0, 5, then ADD r3, r1, r2 -> reg3 = 15, cc = 001, retire pulses exactly 3 times, 4 cycles per instruction.
2. SUB r4, r2, r1 (5-10) -> reg4 = 16'hFFFB, cc = 100. Then AND/OR with r1 = F0F0 and r2 = 0FF0 (loaded via ADDI chains or a preloaded bench program) -> 00F0 and FFF0 respectively.
3. CMP r1, r1 -> cc = 010, destination register unchanged (check via dbg). Then BR mask = 010, off9 = +3 at pc = 20 -> pc = 24. Then BR mask = 101 -> not taken, pc + 1.
4. BR with off9 = -1 (9'h1FF) -> pc unchanged (tight loop). Separately, force a 16'hFFFF wrap -> pc = 0.
5. inst_valid held low for 5 cycles in FETCH -> pc stable, no state advance. Then an illegal opcode 0x9 -> halted = illegal = 1, inst_ready = 0, no retire.
6. Assert rst during EXEC of ADD r5 -> reg5 stays 0, pc = RESET_PC, cc = 010. HALT instruction -> halted = 1 and remains so until rst.
